// File: rtl/prog_logic_fn_pkg.sv
// -----------------------------------------------------------------------------
// prog_logic_pkg
// Shared definitions for the programmable logic function and its sweep checker:
//   - state_t      : controller states (IDLE, LOAD, DRIVE, SAMPLE, DONE)
//   - table_depth(): number of truth-table entries for a given input count
// Optional build macro used by the files of this block: FAIL_MAP_EN.
// -----------------------------------------------------------------------------
package prog_logic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRIVE  = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Truth-table depth is 2^n_in entries.
    function automatic int table_depth(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/prog_logic_fn_if.sv
// -----------------------------------------------------------------------------
// prog_logic_fn_if
// Bundles the function, table-load and sweep signals of prog_logic_fn.
//   x_in        : function input (run mode)
//   y_out       : registered table[x_in]
//   load_start  : pulse, begin serial table load
//   load_bit    : serial table data, code 0 first
//   load_valid  : qualifies load_bit
//   sweep_start : pulse, begin exhaustive sweep
//   stim_out    : code driven into the external block under check
//   dut_y       : response of the external block
//   busy        : controller not idle
//   sweep_done  : one-cycle pulse at end of sweep
//   sweep_fail  : sticky, any mismatch in the last sweep
//   fail_code   : first mismatching code in the last sweep
//   fail_map    : per-code mismatch bits (only when FAIL_MAP_EN is defined)
// Modports: master = environment driving the block, slave = prog_logic_fn.
// -----------------------------------------------------------------------------
interface prog_logic_fn_if #(
    parameter int N_IN = 3
);
    logic [N_IN-1:0]      x_in;
    logic                 y_out;
    logic                 load_start;
    logic                 load_bit;
    logic                 load_valid;
    logic                 sweep_start;
    logic [N_IN-1:0]      stim_out;
    logic                 dut_y;
    logic                 busy;
    logic                 sweep_done;
    logic                 sweep_fail;
    logic [N_IN-1:0]      fail_code;
`ifdef FAIL_MAP_EN
    logic [(1<<N_IN)-1:0] fail_map;

    modport master (
        output x_in, load_start, load_bit, load_valid, sweep_start, dut_y,
        input  y_out, stim_out, busy, sweep_done, sweep_fail, fail_code, fail_map
    );

    modport slave (
        input  x_in, load_start, load_bit, load_valid, sweep_start, dut_y,
        output y_out, stim_out, busy, sweep_done, sweep_fail, fail_code, fail_map
    );
`else
    modport master (
        output x_in, load_start, load_bit, load_valid, sweep_start, dut_y,
        input  y_out, stim_out, busy, sweep_done, sweep_fail, fail_code
    );

    modport slave (
        input  x_in, load_start, load_bit, load_valid, sweep_start, dut_y,
        output y_out, stim_out, busy, sweep_done, sweep_fail, fail_code
    );
`endif

endinterface

// File: rtl/prog_logic_fn_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// prog_logic_sweep_ctrl
// Code and settle counters plus the compare/fail bookkeeping for the sweep.
//   clk, reset  : clock, asynchronous active-high reset
//   state       : current controller state (from prog_logic_fn)
//   sweep_go    : accepted sweep start, clears code and results
//   tbl         : committed truth table
//   dut_y       : response of the external block
//   code        : current sweep code (N_IN+1 bits, terminal compare never wraps)
//   settle_done : last DRIVE cycle of the current code
//   last_code   : current code is the final table entry
//   sweep_fail  : sticky mismatch flag
//   fail_code   : first mismatching code
//   fail_map    : per-code mismatch bits (FAIL_MAP_EN only)
// -----------------------------------------------------------------------------
module prog_logic_sweep_ctrl
    import prog_logic_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  state_t                        state,
    input  logic                          sweep_go,
    input  logic [table_depth(N_IN)-1:0]  tbl,
    input  logic                          dut_y,
    output logic [N_IN:0]                 code,
    output logic                          settle_done,
    output logic                          last_code,
    output logic                          sweep_fail,
    output logic [N_IN-1:0]               fail_code
`ifdef FAIL_MAP_EN
    ,
    output logic [table_depth(N_IN)-1:0]  fail_map
`endif
);

    localparam int DEPTH = table_depth(N_IN);
    localparam int SW    = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    logic [SW-1:0] settle_cnt;
    logic          mismatch;

    assign settle_done = (state == DRIVE) && (settle_cnt == SW'(SETTLE - 1));
    assign last_code   = (code == (N_IN+1)'(DEPTH - 1));
    assign mismatch    = (state == SAMPLE) && (dut_y != tbl[code[N_IN-1:0]]);

    // Settle counter runs only while a code is being driven.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if ((state == DRIVE) && !settle_done) begin
            settle_cnt <= settle_cnt + SW'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code <= '0;
        end else if (sweep_go) begin
            code <= '0;
        end else if ((state == SAMPLE) && !last_code) begin
            code <= code + (N_IN+1)'(1);
        end
    end

    // fail_code latches only on the first mismatch of a sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sweep_fail <= 1'b0;
            fail_code  <= '0;
        end else if (sweep_go) begin
            sweep_fail <= 1'b0;
            fail_code  <= '0;
        end else if (mismatch) begin
            sweep_fail <= 1'b1;
            if (!sweep_fail) begin
                fail_code <= code[N_IN-1:0];
            end
        end
    end

`ifdef FAIL_MAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_map <= '0;
        end else if (sweep_go) begin
            fail_map <= '0;
        end else if (mismatch) begin
            fail_map[code[N_IN-1:0]] <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/prog_logic_fn.sv
// -----------------------------------------------------------------------------
// prog_logic_fn
// Programmable N_IN-input logic function with a hardware truth-table checker.
// Holds a 2^N_IN-bit table, registers y_out = table[x_in] every cycle, accepts
// a serially loaded replacement table (committed atomically after the last
// bit), and can sweep every input code into an external block, comparing its
// response with the table.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears all state
//   bus   : prog_logic_fn_if.slave (x_in/y_out, load_*, sweep_*, stim_out,
//           dut_y, busy, sweep_done, sweep_fail, fail_code[, fail_map])
// Parameters: N_IN (1..8), DEFAULT_TABLE (reset table, bit k = output for
//   code k), SETTLE (cycles each sweep code is held before sampling, >= 1).
// Build macro: FAIL_MAP_EN adds the per-code fail_map output.
// -----------------------------------------------------------------------------
module prog_logic_fn
    import prog_logic_pkg::*;
#(
    parameter int                         N_IN          = 3,
    parameter logic [table_depth(N_IN)-1:0] DEFAULT_TABLE = 8'b0011_1100,
    parameter int                         SETTLE        = 2
) (
    input  logic            clk,
    input  logic            reset,
    prog_logic_fn_if.slave  bus
);

    localparam int DEPTH = table_depth(N_IN);

    state_t           state;
    state_t           state_nxt;
    logic [DEPTH-1:0] tbl;
    logic [DEPTH-1:0] shadow;
    logic [DEPTH-1:0] shadow_nxt;
    logic [N_IN-1:0]  idx;
    logic [N_IN:0]    code;
    logic             load_go;
    logic             sweep_go;
    logic             load_last;
    logic             settle_done;
    logic             last_code;

    // Load has priority when both starts arrive together; starts are only
    // honoured from IDLE.
    assign load_go   = (state == IDLE) && bus.load_start;
    assign sweep_go  = (state == IDLE) && bus.sweep_start && !bus.load_start;
    assign load_last = (state == LOAD) && bus.load_valid && (idx == N_IN'(DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.load_start) begin
                    state_nxt = LOAD;
                end else if (bus.sweep_start) begin
                    state_nxt = DRIVE;
                end
            end
            LOAD: begin
                if (load_last) begin
                    state_nxt = IDLE;
                end
            end
            DRIVE: begin
                if (settle_done) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                state_nxt = last_code ? DONE : DRIVE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // stim_out follows the code only while a code is being held; it reads 0
    // in DONE and IDLE.
    always_comb begin
        bus.busy       = (state != IDLE);
        bus.sweep_done = (state == DONE);
        bus.stim_out   = '0;
        if ((state == DRIVE) || (state == SAMPLE)) begin
            bus.stim_out = code[N_IN-1:0];
        end
    end

    // Shadow with the incoming bit merged, so the last bit and the commit
    // happen on the same edge.
    always_comb begin
        shadow_nxt      = shadow;
        shadow_nxt[idx] = bus.load_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl    <= DEFAULT_TABLE;
            shadow <= DEFAULT_TABLE;
            idx    <= '0;
        end else if (load_go) begin
            shadow <= tbl;
            idx    <= '0;
        end else if ((state == LOAD) && bus.load_valid) begin
            shadow <= shadow_nxt;
            idx    <= idx + N_IN'(1);
            if (load_last) begin
                tbl <= shadow_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.y_out <= 1'b0;
        end else begin
            bus.y_out <= tbl[bus.x_in];
        end
    end

    prog_logic_sweep_ctrl #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_sweep_ctrl (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .sweep_go    (sweep_go),
        .tbl         (tbl),
        .dut_y       (bus.dut_y),
        .code        (code),
        .settle_done (settle_done),
        .last_code   (last_code),
        .sweep_fail  (bus.sweep_fail),
        .fail_code   (bus.fail_code)
`ifdef FAIL_MAP_EN
        ,
        .fail_map    (bus.fail_map)
`endif
    );

endmodule
